// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial adder controller.
//   state_e       : controller state encoding (IDLE, RUN, DONE), 2 bits
//   DEFAULT_WIDTH : default operand width
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// 1-bit combinational full adder, stepped once per clock by the controller.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   co_o     : carry out
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder sequencer: latches operands on start, adds one bit per
// clock (LSB first) through a single full-adder cell, then presents the
// result with a one-cycle done pulse.
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, honoured in IDLE or DONE
//   a, b, cin     : operands and carry-in, captured on the accepting edge
//   busy          : high while the addition is in progress
//   done          : one-cycle pulse, result valid
//   sum, cout     : WIDTH-bit result and carry out of the MSB
//   ovf           : two's-complement overflow
module bit_serial_adder_ctrl
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q;
  logic [WIDTH-1:0] a_sr_d, b_sr_d, s_sr_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_c_q;
  logic             fa_s, fa_co;
  logic             last;

  serial_fa_cell u_cell (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    a_sr_d = a_sr_q >> 1;
    b_sr_d = b_sr_q >> 1;
    s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};
    last   = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_c_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          a_sr_q  <= a_sr_d;
          b_sr_q  <= b_sr_d;
          s_sr_q  <= s_sr_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            // carry_q here is the carry into the MSB
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= s_sr_d;
            cout_q  <= fa_co;
            ovf_c_q <= carry_q;
            cnt_q   <= '0;
          end
        end
        default: begin  // IDLE and DONE both accept a new request
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_sr_q  <= a;
            b_sr_q  <= b;
            s_sr_q  <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_c_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  // Overflow is carry-in XOR carry-out of the MSB, both held in registers.
  assign ovf  = ovf_c_q ^ cout_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Waits out the RUN phase after an accept edge, checking busy, then
  // checks the done cycle and its result.
  task automatic run_and_check(input string nm, input logic [W-1:0] es,
                               input logic ec, input logic eo);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run%0d busy=%b done=%b want busy=1 done=0", nm, i, busy, done);
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== es || cout !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL %s done=%b busy=%b sum=%h cout=%b ovf=%b want done=1 busy=0 sum=%h cout=%b ovf=%b",
               nm, done, busy, sum, cout, ovf, es, ec, eo);
    end
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ia, ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, eo);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; cin = ~ic;  // must be ignored during RUN
    checks++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear sum=%h cout=%b ovf=%b want 0", nm, sum, cout, ovf);
    end
    @(posedge clk);
    // first RUN cycle already passed; check the remaining W-1 plus done
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s run%0d busy=%b done=%b want busy=1 done=0", nm, i, busy, done);
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== es || cout !== ec || ovf !== eo) begin
      errors++;
      $display("FAIL %s done=%b busy=%b sum=%h cout=%b ovf=%b want done=1 busy=0 sum=%h cout=%b ovf=%b",
               nm, done, busy, sum, cout, ovf, es, ec, eo);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== es) begin
      errors++;
      $display("FAIL %s_idle done=%b busy=%b sum=%h want done=0 busy=0 sum=%h", nm, done, busy, sum, es);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_arith();
    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("add_cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_run();
    int ndone = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;  // RUN cycle 3
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL ignore_start sum=%h cout=%b ovf=%b want 30 0 0", sum, cout, ovf);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_start_count got %0d done pulses want 1", ndone);
    end
  endtask

  task automatic test_reset_in_run();
    int ndone = 0;
    @(negedge clk);
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;  // RUN cycle 4
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort busy=%b done=%b sum=%h cout=%b ovf=%b want all 0", busy, done, sum, cout, ovf);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d busy/done cycles want 0", ndone);
    end
    do_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int r = 0; r < 3; r++) run_and_check($sformatf("b2b%0d", r), 8'h07, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h07) begin
      errors++;
      $display("FAIL b2b_end busy=%b done=%b sum=%h want 0 0 07", busy, done, sum);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_start_in_run();
    test_reset_in_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder_ctrl.md
# bit_serial_adder_ctrl

Sequencer that reuses a single 1-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start handshake, steps the cell WIDTH times while holding the carry in a register, and presents sum, carry-out and signed overflow with a one-cycle done pulse. It sits between a requesting master (CPU/test FSM) and the adder cell, trading latency for area.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; held from done until the next accepted start.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a, b into shift registers and cin into the carry register; clear the bit counter; go to RUN.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - Feed the cell the LSBs of the A/B shift registers and the carry register.
  - Shift the cell sum bit into the MSB of the sum shift register, which shifts right.
  - Write the cell carry into the carry register; shift A and B right.
  - Counter increments.
  - On the edge where counter = WIDTH-1, capture the carry register value (the carry into the MSB) into ovf_c, load cout, set ovf, and go to DONE.
- DONE, lasts one cycle:
  - done=1, busy=0.
  - start=1 → accepted exactly as in IDLE, go to RUN (back-to-back).
  - start=0 → go to IDLE.
- start while in RUN is ignored, with no queuing; a, b and cin changes during RUN have no effect.
- sum, cout and ovf are registered. They change only at the end of RUN, and also on the start-accept edge, when they are cleared to 0. Outputs are therefore valid from done until the next accept.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the 2^WIDTH bit; ovf treats operands as two's complement.
- Counter width is $clog2(WIDTH); it resets to 0 and holds in IDLE and DONE.

## Timing
- Reset, synchronous and checked first on every edge:
  - state=IDLE, busy=0, done=0.
  - sum=0, cout=0, ovf=0.
  - carry register=0, counter=0.
- Reset in RUN aborts the operation: no done pulse, and outputs go to the reset values at that edge.
- Latency: with start accepted at edge E, busy is high during cycles E+1 .. E+WIDTH. done is high for exactly the cycle after edge E+WIDTH, and sum/cout/ovf are valid in that cycle.
- Throughput: back-to-back starts give one result every WIDTH+1 cycles.
- The cell is purely combinational and sits between registers; there is no combinational path from inputs to outputs.
- busy and done are never high together.

## Structure
- Package bit_serial_pkg:
  - state enum (IDLE, RUN, DONE), 2-bit encoding.
  - DEFAULT_WIDTH = 8.
- One sub-module, serial_fa_cell: a 1-bit full adder (a, b, cin → s, cout), instantiated once.
- The controller owns all registers: the three shift registers, the carry register, the counter, the state register, and cout, ovf and ovf_c.

## Test plan
- WIDTH=8, reset then start with a=0x5A, b=0x3C, cin=0 → busy high for 8 cycles; done 9 cycles after the accept edge; sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- Start accepted with 0x10+0x20, then pulse start with different operands at RUN cycle 3 → ignored; single done with sum=0x30.
- rst asserted during RUN cycle 4 → next cycle busy=0, done=0, sum=0, and no done pulse ever appears; a subsequent 0x01+0x01 gives sum=0x02.
- start held high continuously with fixed operands 0x03+0x04 → done pulses every 9 cycles, each with sum=0x07, and busy low only in the done cycles.
